// File: rtl/l1_cache_pkg.sv
// Shared L1 cache definitions: default widths, miss-handler state encoding
// and the client request record shared with the return stage.
package l1_cache_pkg;

   localparam int L1_ADDR_W = 16;
   localparam int L1_LINE_W = 256;

   // Miss-handler states; the encoding is also visible on the debug port.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_REQ    = 2'd2,
      ST_FILL   = 2'd3
   } l1_miss_state_t;

   // Client request as queued and handed to the return stage.
   typedef struct packed {
      logic [L1_ADDR_W-1:0] addr;
   } l1_req_t;

endpackage

// File: rtl/l1_req_fifo.sv
// Client request queue: synchronous FIFO, asynchronous active-high reset.
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
// A push while full and a pop while empty are both dropped.
module l1_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/l1_miss_to_l2_request.sv
// L1 miss handler: queues client reads, looks each one up in the L1 tags,
// acknowledges hits and sends misses to L2 one at a time, then hands the
// returned line to the return stage as a single-cycle fill strobe.
// Optional feature macro: L1_MISS_TIMEOUT_EN (abandon an L2 request after
// TIMEOUT_CYC cycles without ack and pulse timeout_err).
//
// Handshakes: a client push happens on cl_req_valid && cl_req_ready;
// req_to_l2 stays high with a stable address until ack_from_l2 is sampled
// high; hit_to_cl, ack_to_l1 and timeout_err are one-cycle registered pulses
// with no back-pressure, and their address/data are valid only while high.
module l1_miss_to_l2_request
   import l1_cache_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_W      = L1_ADDR_W,
   parameter int LINE_W      = L1_LINE_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cl_req_valid,
   input  logic [ADDR_W-1:0]           cl_req_addr,
   output logic                        cl_req_ready,
   output logic                        lookup_valid,
   output logic [ADDR_W-1:0]           lookup_addr,
   input  logic                        lookup_hit,
   output logic                        hit_to_cl,
   output logic [ADDR_W-1:0]           hit_addr,
   output logic                        req_to_l2,
   output logic [ADDR_W-1:0]           req_addr_to_l2,
   input  logic                        ack_from_l2,
   input  logic [LINE_W-1:0]           data_from_l2,
   output logic                        ack_to_l1,
   output logic [ADDR_W-1:0]           fill_addr,
   output logic [LINE_W-1:0]           fill_data,
   output logic                        timeout_err,
   output logic [1:0]                  dbg_state,
   output logic [$clog2(FIFO_DEPTH):0] dbg_q_count
);

   l1_miss_state_t    state;
   l1_miss_state_t    next_state;
   logic              q_full;
   logic              q_empty;
   logic              q_pop;
   logic [ADDR_W-1:0] q_head;
   logic              hit_take;
   logic              fill_load;

   assign cl_req_ready   = !q_full;
   assign lookup_valid   = (state == ST_LOOKUP);
   assign lookup_addr    = lookup_valid ? q_head : '0;
   assign req_to_l2      = (state == ST_REQ);
   assign req_addr_to_l2 = req_to_l2 ? q_head : '0;
   assign ack_to_l1      = (state == ST_FILL);
   assign dbg_state      = state;

   l1_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ADDR_W)
   ) u_req_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cl_req_valid && cl_req_ready),
      .push_data (cl_req_addr),
      .pop       (q_pop),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (dbg_q_count)
   );

`ifdef L1_MISS_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_fire;

   // The counter reaches TIMEOUT_CYC on the edge that ends this REQ cycle.
   assign tmo_fire = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   // Count REQ cycles without ack; held at zero outside REQ so entry clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= (state == ST_REQ) && !ack_from_l2 && tmo_fire;
         if (state != ST_REQ) begin
            tmo_cnt <= '0;
         end else if (!ack_from_l2) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   // Next state and queue pop; lookup_hit and ack_from_l2 only matter in
   // their own states, and ack beats a simultaneous timeout.
   always_comb begin
      next_state = state;
      q_pop      = 1'b0;
      hit_take   = 1'b0;
      fill_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!q_empty) next_state = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (lookup_hit) begin
               hit_take   = 1'b1;
               q_pop      = 1'b1;
               next_state = ST_IDLE;
            end else begin
               next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_from_l2) begin
               fill_load  = 1'b1;
               next_state = ST_FILL;
            end
`ifdef L1_MISS_TIMEOUT_EN
            else if (tmo_fire) begin
               q_pop      = 1'b1;
               next_state = ST_IDLE;
            end
`endif
         end
         ST_FILL: begin
            q_pop      = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State, hit acknowledge and the registered fill line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         hit_to_cl <= 1'b0;
         hit_addr  <= '0;
         fill_addr <= '0;
         fill_data <= '0;
      end else begin
         state     <= next_state;
         hit_to_cl <= hit_take;
         if (hit_take) hit_addr <= q_head;
         if (fill_load) begin
            fill_addr <= q_head;
            fill_data <= data_from_l2;
         end
      end
   end

endmodule

// File: doc/l1_miss_to_l2_request.md
# l1_miss_to_l2_request

Miss-handling stage that sits directly upstream of the L1-to-client return stage. Client read requests are queued, looked up in the L1 tag array, and either acknowledged as hits or sent to L2 as line requests. When L2 acknowledges a request, the block registers the returned 256-bit line and issues a single-cycle `ack_to_l1` with the fill address and data, which the return stage consumes to write the line and answer the client. Only one L2 miss is outstanding at a time.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: client request queue entries; must be a power of two and at least 2.
- `ADDR_W`, 16: address width.
- `LINE_W`, 256: cache line width.
- `TIMEOUT_CYC`, 255: L2 ack timeout in cycles; used only when `L1_MISS_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cl_req_valid`  in  1  client request valid.
- `cl_req_addr`  in  ADDR_W  client request address.
- `cl_req_ready`  out  1  queue can accept; equals `!full`.
- `lookup_valid`  out  1  tag lookup strobe to L1.
- `lookup_addr`  out  ADDR_W  address being looked up.
- `lookup_hit`  in  1  same-cycle lookup result from L1.
- `hit_to_cl`  out  1  one-cycle hit acknowledge to the client.
- `hit_addr`  out  ADDR_W  address of the hit; valid while `hit_to_cl` is high.
- `req_to_l2`  out  1  L2 line request, held high until acknowledged.
- `req_addr_to_l2`  out  ADDR_W  requested line address.
- `ack_from_l2`  in  1  L2 acknowledge; qualifies `data_from_l2`.
- `data_from_l2`  in  LINE_W  returned line.
- `ack_to_l1`  out  1  one-cycle fill strobe to the return stage.
- `fill_addr`  out  ADDR_W  fill address; valid while `ack_to_l1` is high.
- `fill_data`  out  LINE_W  fill line; valid while `ack_to_l1` is high.
- `timeout_err`  out  1  one-cycle timeout pulse.

## Operation
Request queue:
- A push occurs when `cl_req_valid && cl_req_ready`.
- When the queue is full, `cl_req_ready` is 0, even if a pop happens in the same cycle.
- The entry at the head is popped only on a hit, a fill, or a timeout.

State machine states: IDLE, LOOKUP, REQ, FILL.
- IDLE: if the queue is non-empty, go to LOOKUP; otherwise stay in IDLE.
- LOOKUP:
  - `lookup_valid` = 1 and `lookup_addr` = head address for exactly one cycle.
  - If `lookup_hit` is 1: pop the head, register `hit_to_cl` = 1 and `hit_addr` for the next cycle, and go to IDLE.
  - If `lookup_hit` is 0: go to REQ.
- REQ:
  - `req_to_l2` = 1 and `req_addr_to_l2` = head address, held stable until ack.
  - When `ack_from_l2` is sampled high, register `data_from_l2` into `fill_data` and the head address into `fill_addr`, then go to FILL.
- FILL: `ack_to_l1` = 1 for one cycle, pop the head, go to IDLE.

Boundary conditions:
- `ack_from_l2` outside REQ is ignored, with no state or data change.
- `lookup_hit` outside LOOKUP is ignored.
- Requests are serviced strictly in arrival order. A hit never overtakes an outstanding miss.
- Duplicate addresses are not merged; each one performs its own lookup.
- A client push in the same cycle as a pop is accepted if the queue was not full.
- Reset mid-operation: all state returns to IDLE immediately, the queue empties, and `req_to_l2` drops asynchronously. A late `ack_from_l2` is ignored because the block is in IDLE.

## Timing
Reset values:
- All outputs are 0, except `cl_req_ready` = 1.
- `fill_data`, `fill_addr`, `hit_addr`, `req_addr_to_l2` and `lookup_addr` are 0.

Latency, taking push into an empty queue in cycle 0:
- IDLE in cycle 1, LOOKUP in cycle 2.
- Hit: `hit_to_cl` high in cycle 3.
- Miss: `req_to_l2` high from cycle 3. An ack in cycle N gives `ack_to_l1` in cycle N+1; the minimum is cycle 4.

Other timing rules:
- `lookup_valid` and `req_to_l2` are decoded from registered state; they have no combinational path from inputs.
- `hit_to_cl`, `ack_to_l1` and `timeout_err` are registered pulses, never asserted simultaneously.
- Back-to-back hits: one every 2 cycles (LOOKUP, IDLE).

## Configuration
`L1_MISS_TIMEOUT_EN` defined:
- An 8+ bit counter clears on entry to REQ and increments every REQ cycle without ack.
- When the counter reaches `TIMEOUT_CYC`, `timeout_err` pulses the next cycle, `req_to_l2` drops, the head is popped with no fill, and the state goes to IDLE.
- An ack in the same cycle as the counter reaching `TIMEOUT_CYC` wins: the request fills and there is no timeout.

`L1_MISS_TIMEOUT_EN` undefined:
- REQ waits indefinitely and there is no counter.
- `timeout_err` is tied to 0.

## Structure
- Package `l1_cache_pkg`: `ADDR_W`/`LINE_W` defaults, the state enum typedef `l1_miss_state_t`, and a request struct (address) shared with the return stage.
- Sub-module `l1_req_fifo`: parameterised synchronous FIFO with async reset, providing `push`, `pop`, `head`, `full`, `empty`, and count.
- The top level holds the FSM, the fill registers, and the optional timeout counter.

## Test plan
- Reset, then push 0x1234 with `lookup_hit` = 1 → `lookup_valid` in cycle 2, then `hit_to_cl` with `hit_addr` = 0x1234 in cycle 3, with no `req_to_l2`.
- Push 0x00A0 and miss; L2 acks 5 cycles after `req_to_l2` rises with data 256'hDEAD…BEEF → `req_addr_to_l2` = 0x00A0 is stable throughout, then a single `ack_to_l1` pulse with `fill_addr` = 0x00A0 and `fill_data` = 256'hDEAD…BEEF.
- Push 5 requests back-to-back with `FIFO_DEPTH` = 4 while the first misses → `cl_req_ready` = 0 after 4 pushes, the 5th is accepted after the first fill, and all are serviced in order.
- Pulse `ack_from_l2` while in IDLE and LOOKUP → no `ack_to_l1`, and `fill_data` is unchanged.
- Assert `rst` while `req_to_l2` is high, then deliver an ack after reset → `req_to_l2` = 0 immediately, all outputs are at reset values, and no fill occurs.
- With `L1_MISS_TIMEOUT_EN` and `TIMEOUT_CYC` = 8, a miss with no ack → `timeout_err` pulses after 8 REQ cycles, the head is dropped, and the next queued request proceeds.
